// File: rtl/game_pkg.sv
// Per-character sprite constants and the shared timing-bus layout for the VGA pipeline.
package game_pkg;

   localparam int SCREEN_W = 800;
   localparam int SCREEN_H = 600;

   localparam int          TOM_WIDTH      = 64;
   localparam int          TOM_HEIGHT     = 64;
   localparam logic [11:0] TOM_BG_COLOR   = 12'h0F0;
   localparam int          TOM_FRAMES     = 4;

   localparam int          JERRY_WIDTH    = 32;
   localparam int          JERRY_HEIGHT   = 32;
   localparam logic [11:0] JERRY_BG_COLOR = 12'hF0F;
   localparam int          JERRY_FRAMES   = 2;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
   } vga_timing_t;

endpackage

// File: rtl/vga_if.sv
// Timing and colour bus passed between stages of the VGA pixel pipeline.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/delay.sv
// Fixed-length shift register used to align side-band signals with a latency path.
module delay #(
   parameter int WIDTH   = 1,
   parameter int CLK_DEL = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout
);

   logic [WIDTH-1:0] r_pipe [CLK_DEL];

   // NOTE: every stage is reset, not just the head, so a mid-frame reset flushes stale pixels.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CLK_DEL; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_din;
         for (int i = 1; i < CLK_DEL; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_dout = r_pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: fetches pixels from a synchronous ROM and keys them over the background,
// with animation frames, mirroring and position latched at vertical blank.
module draw_sprite
   import game_pkg::*;
#(
   parameter int          SPR_WIDTH   = 64,
   parameter int          SPR_HEIGHT  = 64,
   parameter int          FRAMES      = 4,
   parameter int          FRAME_TICKS = 8,
   parameter logic [11:0] BG_COLOR    = 12'h0F0,
   parameter int          ROM_LATENCY = 1,
   parameter int          ADDR_WIDTH  = 20
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [9:0]            pos_x,
   input  logic [9:0]            pos_y,
   input  logic                  mirror,
   input  logic                  visible,
   input  logic                  anim_en,
   input  logic [11:0]           data,
   vga_if.in                     in,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [3:0]            frame_idx,
   vga_if.out                    out
);

   localparam int DLY   = ROM_LATENCY + 1;
   localparam int BUS_W = $bits(vga_timing_t) + 13;

   logic                  r_vblnk_prev;
   logic [9:0]            r_shadow_x;
   logic [9:0]            r_shadow_y;
   logic                  r_shadow_mirror;
   logic                  r_shadow_visible;
   logic [7:0]            r_tick_cnt;
   logic [3:0]            r_frame_idx;
   logic [ADDR_WIDTH-1:0] r_address;

   logic                  w_vblnk_rise;
   logic                  w_in_win;
   logic [10:0]           w_x0;
   logic [10:0]           w_y0;
   logic [10:0]           w_lx;
   logic [10:0]           w_ly;
   logic [10:0]           w_ex;
   logic [31:0]           w_addr;
   vga_timing_t           w_timing;
   vga_timing_t           w_timing_d;
   logic [11:0]           w_rgb_d;
   logic                  w_in_win_d;
   logic [BUS_W-1:0]      w_bus_d;

   assign w_vblnk_rise = in.vblnk & ~r_vblnk_prev;
   assign w_x0         = {1'b0, r_shadow_x};
   assign w_y0         = {1'b0, r_shadow_y};

   // Bounding against the visible area clips the sprite instead of drawing into blanking.
   assign w_in_win = r_shadow_visible
                  && (in.hcount >= w_x0) && (in.hcount < w_x0 + 11'(SPR_WIDTH))
                  && (in.vcount >= w_y0) && (in.vcount < w_y0 + 11'(SPR_HEIGHT))
                  && (in.hcount < 11'(SCREEN_W)) && (in.vcount < 11'(SCREEN_H));

   assign w_lx   = in.hcount - w_x0;
   assign w_ly   = in.vcount - w_y0;
   assign w_ex   = r_shadow_mirror ? 11'(SPR_WIDTH - 1) - w_lx : w_lx;
   assign w_addr = 32'(r_frame_idx) * 32'(SPR_WIDTH * SPR_HEIGHT)
                 + 32'(w_ly) * 32'(SPR_WIDTH) + 32'(w_ex);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vblnk_prev     <= 1'b0;
         r_shadow_x       <= '0;
         r_shadow_y       <= '0;
         r_shadow_mirror  <= 1'b0;
         r_shadow_visible <= 1'b0;
         r_tick_cnt       <= '0;
         r_frame_idx      <= '0;
      end else begin
         r_vblnk_prev <= in.vblnk;
         if (w_vblnk_rise) begin
            r_shadow_x       <= pos_x;
            r_shadow_y       <= pos_y;
            r_shadow_mirror  <= mirror;
            r_shadow_visible <= visible;
            if (anim_en) begin
               if (r_tick_cnt == 8'(FRAME_TICKS - 1)) begin
                  r_tick_cnt  <= '0;
                  r_frame_idx <= (r_frame_idx == 4'(FRAMES - 1)) ? 4'd0 : r_frame_idx + 4'd1;
               end else begin
                  r_tick_cnt <= r_tick_cnt + 8'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_address <= '0;
      else     r_address <= w_in_win ? ADDR_WIDTH'(w_addr) : '0;
   end

   assign address   = r_address;
   assign frame_idx = r_frame_idx;

   assign w_timing = '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync,
                       vsync: in.vsync, hblnk: in.hblnk, vblnk: in.vblnk};

   delay #(
      .WIDTH   (BUS_W),
      .CLK_DEL (DLY)
   ) u_delay (
      .clk    (clk),
      .rst    (rst),
      .i_din  ({w_timing, in.rgb, w_in_win}),
      .o_dout (w_bus_d)
   );

   assign {w_timing_d, w_rgb_d, w_in_win_d} = w_bus_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         out.hcount <= '0;
         out.vcount <= '0;
         out.hsync  <= 1'b0;
         out.vsync  <= 1'b0;
         out.hblnk  <= 1'b0;
         out.vblnk  <= 1'b0;
         out.rgb    <= '0;
      end else begin
         out.hcount <= w_timing_d.hcount;
         out.vcount <= w_timing_d.vcount;
         out.hsync  <= w_timing_d.hsync;
         out.vsync  <= w_timing_d.vsync;
         out.hblnk  <= w_timing_d.hblnk;
         out.vblnk  <= w_timing_d.vblnk;
         out.rgb    <= (w_in_win_d && (data != BG_COLOR)) ? data : w_rgb_d;
      end
   end

endmodule

// File: tb/tb_draw_sprite.sv
// Scoreboard bench for draw_sprite: a behavioural model predicts every output pixel at drive time.
module tb_draw_sprite;

   localparam int          W  = 4;
   localparam int          H  = 4;
   localparam int          FR = 3;
   localparam int          FT = 2;
   localparam int          RL = 2;
   localparam int          AW = 8;
   localparam int          L  = RL + 2;
   localparam logic [11:0] BG = 12'h0F0;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [9:0]    pos_x = '0;
   logic [9:0]    pos_y = '0;
   logic          mirror = 1'b0;
   logic          visible = 1'b0;
   logic          anim_en = 1'b0;
   logic [11:0]   data;
   logic [AW-1:0] address;
   logic [3:0]    frame_idx;

   vga_if vin();
   vga_if vout();

   logic [11:0] rom [256];
   logic [11:0] rom_p1;
   logic [11:0] rom_p2;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_addr = 0;
   int   m_prev_vb, m_sx, m_sy, m_sm, m_sv, m_tick, m_frame;
   int   seq[7] = '{0, 0, 1, 1, 2, 2, 0};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rom_p1 <= rom[address];
      rom_p2 <= rom_p1;
   end
   assign data = rom_p2;

   draw_sprite #(
      .SPR_WIDTH   (W),
      .SPR_HEIGHT  (H),
      .FRAMES      (FR),
      .FRAME_TICKS (FT),
      .BG_COLOR    (BG),
      .ROM_LATENCY (RL),
      .ADDR_WIDTH  (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .mirror    (mirror),
      .visible   (visible),
      .anim_en   (anim_en),
      .data      (data),
      .in        (vin),
      .address   (address),
      .frame_idx (frame_idx),
      .out       (vout)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step(input logic [10:0] h, input logic [10:0] v, input logic hb,
                       input logic vb, input logic [11:0] rgb);
      exp_t e;
      int   hi, vi, lx, ly, ex, a;
      logic win;
      @(negedge clk);
      if (q.size() == L) begin
         e = q.pop_front();
         check("out_rgb", vout.rgb, e.rgb);
         check("out_timing", {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk},
               {e.h, e.v, e.hs, e.vs, e.hb, e.vb});
      end
      check("address", address, exp_addr);
      check("frame_idx", frame_idx, m_frame);

      hi  = int'(h);
      vi  = int'(v);
      win = (m_sv != 0) && hi >= m_sx && hi < m_sx + W && vi >= m_sy && vi < m_sy + H
            && hi < 800 && vi < 600;
      lx  = hi - m_sx;
      ly  = vi - m_sy;
      ex  = (m_sm != 0) ? W - 1 - lx : lx;
      a   = win ? (m_frame * W * H + ly * W + ex) % 256 : 0;
      e.h   = h;
      e.v   = v;
      e.hs  = h[3];
      e.vs  = v[2];
      e.hb  = hb;
      e.vb  = vb;
      e.rgb = (win && rom[a] != BG) ? rom[a] : rgb;
      q.push_back(e);
      exp_addr = a;

      rst         = 1'b0;
      vin.hcount  = h;
      vin.vcount  = v;
      vin.hsync   = h[3];
      vin.vsync   = v[2];
      vin.hblnk   = hb;
      vin.vblnk   = vb;
      vin.rgb     = rgb;

      if (vb && m_prev_vb == 0) begin
         m_sx = int'(pos_x);
         m_sy = int'(pos_y);
         m_sm = int'(mirror);
         m_sv = int'(visible);
         if (anim_en) begin
            if (m_tick == FT - 1) begin
               m_tick  = 0;
               m_frame = (m_frame == FR - 1) ? 0 : m_frame + 1;
            end else begin
               m_tick++;
            end
         end
      end
      m_prev_vb = int'(vb);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      for (int i = 0; i < L; i++) q.push_back('0);
      exp_addr  = 0;
      m_prev_vb = 0;
      m_sx      = 0;
      m_sy      = 0;
      m_sm      = 0;
      m_sv      = 0;
      m_tick    = 0;
      m_frame   = 0;
   endtask

   task automatic draw_rows(input int v0, input int v1, input int h0, input int h1);
      for (int v = v0; v <= v1; v++)
         for (int h = h0; h <= h1; h++)
            step(11'(h), 11'(v), 1'b0, 1'b0, 12'h200 | 12'(((h & 15) << 4) | (v & 15)));
   endtask

   task automatic vblank();
      step(11'd0, 11'd599, 1'b0, 1'b0, 12'h000);
      step(11'd0, 11'd600, 1'b0, 1'b1, 12'h000);
      step(11'd1, 11'd600, 1'b0, 1'b1, 12'h000);
   endtask

   initial begin
      vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
      vin.hblnk  = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
      for (int a = 0; a < 256; a++) rom[a] = (a < 16) ? 12'hF00 : 12'h100 + 12'(a);
      rom[1] = BG;

      do_reset();
      pos_x = 10'd100; pos_y = 10'd50; visible = 1'b1;
      draw_rows(49, 54, 98, 105);
      vblank();
      draw_rows(49, 54, 98, 105);

      draw_rows(20, 20, 98, 105);
      pos_x = 10'd200;
      draw_rows(30, 30, 98, 105);
      draw_rows(49, 54, 98, 105);
      draw_rows(49, 54, 198, 205);
      draw_rows(300, 300, 198, 205);
      vblank();
      draw_rows(49, 54, 198, 205);
      draw_rows(50, 50, 98, 105);

      for (int a = 0; a < 4; a++) rom[a] = 12'(a);
      pos_x = 10'd100; mirror = 1'b1;
      vblank();
      draw_rows(50, 50, 98, 100);
      @(posedge clk);
      #1;
      check("mirror_addr", address, 3);
      draw_rows(50, 50, 101, 105);
      draw_rows(51, 53, 98, 105);

      mirror = 1'b0; anim_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         check("anim_seq", frame_idx, seq[i]);
         vblank();
         draw_rows(50, 50, 99, 104);
      end
      vblank();
      anim_en = 1'b0;
      vblank();
      vblank();
      check("anim_hold", frame_idx, 1);
      draw_rows(50, 51, 98, 105);

      draw_rows(52, 52, 98, 101);
      do_reset();
      draw_rows(52, 52, 102, 105);
      draw_rows(50, 53, 98, 105);
      vblank();
      draw_rows(50, 53, 98, 105);

      pos_x = 10'd798; pos_y = 10'd598;
      vblank();
      draw_rows(596, 605, 796, 805);
      draw_rows(598, 599, 0, 3);
      pos_x = 10'd900; pos_y = 10'd50;
      vblank();
      draw_rows(50, 51, 898, 905);
      draw_rows(50, 51, 0, 3);

      draw_rows(0, 0, 0, L + 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/draw_sprite.md
# draw_sprite

Parametrised sprite overlay stage for the VGA pixel pipeline, the successor to the fixed-size single-character draw stages. It sits between two `vga_if` stages: it fetches sprite pixels from an external synchronous ROM and overlays them on the incoming background with a colour-key transparency.
- Additions over the previous generation: multi-frame animation, horizontal mirroring, a visibility enable, and tear-free position update latched at vertical blank.
- Every game character (Tom, Jerry, items) is one instance with its own parameters.

## Interface
Parameters:
- `SPR_WIDTH`, default 64: sprite width in pixels (1..512).
- `SPR_HEIGHT`, default 64: sprite height in pixels (1..512).
- `FRAMES`, default 4: animation frames stored consecutively in ROM (1..16).
- `FRAME_TICKS`, default 8: video frames each animation frame is shown (1..255).
- `BG_COLOR`, default 12'h0F0: transparent colour key.
- `ROM_LATENCY`, default 1: ROM read latency in clocks (1..3).
- `ADDR_WIDTH`, default 20: ROM address width.

Ports:
- `clk` in, 1: pixel clock.
- `rst` in, 1: reset. One clock; reset is synchronous and active-high.
- `pos_x` in, 10: requested sprite left edge (screen pixels).
- `pos_y` in, 10: requested sprite top edge.
- `mirror` in, 1: requested horizontal flip.
- `visible` in, 1: requested visibility.
- `anim_en` in, 1: animation advance enable.
- `data` in, 12: ROM pixel, valid `ROM_LATENCY` clocks after `address`.
- `in` vga_if.in: upstream timing and rgb.
- `address` out, `ADDR_WIDTH`: ROM address, registered.
- `frame_idx` out, 4: current animation frame.
- `out` vga_if.out: downstream timing and rgb.

## Operation
- **Shadow registers.** `pos_x`, `pos_y`, `mirror` and `visible` are captured into shadow registers only on the cycle where `in.vblnk` rises (it was 0 on the previous cycle and is 1 now). All drawing uses the shadow values, so mid-frame changes never tear.
- **Animation counter.**
  - `tick_cnt` increments on each `in.vblnk` rising edge while `anim_en` = 1.
  - When `tick_cnt` reaches `FRAME_TICKS`-1, `tick_cnt` goes to 0 and `frame_idx` advances, wrapping from `FRAMES`-1 to 0.
  - `anim_en` = 0 freezes both counters at their current values.
- **Window test.** All comparisons are 11-bit, so `x+SPR_WIDTH` never wraps. The pixel is inside the window when:
  - `in.hcount` ≥ shadow_x and `in.hcount` < shadow_x+`SPR_WIDTH`, and
  - `in.vcount` ≥ shadow_y and `in.vcount` < shadow_y+`SPR_HEIGHT`, and
  - shadow_visible = 1.
- **Address.**
  - Local coordinates: lx = hcount−x, ly = vcount−y.
  - Effective x: ex = `SPR_WIDTH`−1−lx when mirrored, otherwise lx.
  - address = frame_idx·`SPR_WIDTH`·`SPR_HEIGHT` + ly·`SPR_WIDTH` + ex, truncated to `ADDR_WIDTH`.
  - Outside the window, address = 0.
- **Pixel mux.** The in-window flag is delayed alongside the data. out.rgb = `data` when the delayed flag is 1 and `data` ≠ `BG_COLOR`; otherwise out.rgb = the delayed in.rgb.
- **Pass-through.** hcount, vcount, hsync, vsync, hblnk and vblnk pass through unchanged, delayed.
- **Off-screen and clipped sprites.** A sprite partially off-screen is clipped naturally. A sprite with x ≥ 800 or y ≥ 600 draws nothing.

## Timing
- Total latency L = `ROM_LATENCY`+2 clocks, from any `in` field to the matching `out` field. All `out` fields are aligned with each other.
- Pipeline stages:
  - Cycle 1: window test and registered `address`.
  - Cycles 2..`ROM_LATENCY`+1: ROM access.
  - Cycle L: registered rgb mux.
- Reset values: all `out` fields 0, `address` 0, `frame_idx` 0, `tick_cnt` 0, shadow position 0, shadow_mirror 0, shadow_visible 0.
  - After reset the sprite is hidden until the first vblank rising edge.
- Reset asserted mid-frame: on the next clock, outputs are 0 and the delay line is cleared. Normal pass-through resumes L clocks after release.
- Simultaneous events: a vblank edge coinciding with changed inputs captures the new values. The animation step and the shadow capture happen on the same edge.
- Position values take effect at the first active line after the capturing vblank.

## Structure
- `game_pkg` holds per-character constants (`TOM_WIDTH`, `TOM_HEIGHT`, `TOM_BG_COLOR`, `TOM_FRAMES`, and the Jerry equivalents) used to parameterise instances. No logic lives in the package.
- Sub-module: the existing `delay` handles the L−1 stage alignment of the timing bus, in.rgb and the in-window flag.
- The vblank edge detector, animation counters and address arithmetic live in `draw_sprite` itself.

## Test plan
- Static draw: W=H=4, pos (100,50), ROM filled with 12'hF00. Required: out.rgb = F00 exactly at hcount 100..103 and vcount 50..53, L clocks after input; background elsewhere.
- Transparency: ROM word at ly=0, lx=1 equals `BG_COLOR`. Required: pixel (101,50) shows the input rgb; its neighbours show F00.
- Mirror: ROM row 0 = 0,1,2,3 with `mirror`=1. Required: hcount 100..103 output 3,2,1,0; `address` at hcount 100 = 3.
- Tear-free update: change `pos_x` to 200 at vcount 300. Required: the rest of that frame still draws at 100; the next frame draws at 200.
- Animation: FRAMES=3, FRAME_TICKS=2, `anim_en`=1 over 7 vblanks. Required: `frame_idx` sequence 0,0,1,1,2,2,0; base address = frame_idx·16. With `anim_en`=0 the value holds.
- Reset and edges: assert `rst` mid-line. Required: all outputs 0 next clock, sprite hidden until the next vblank. Pos (790,590) with W=H=16 is clipped, with no wrap to x=0.
